// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: ARM condition codes,
// NZCV flag bit positions and the IT sequencer state encoding.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: (cond, NZCV flags) -> pass.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic_it.sv
// Conditional-execution unit with NZCV flag register and an IT-block sequencer
// that overrides the condition of up to IT_MAX_LEN following instructions.
module cond_logic_it
  import cond_pkg::*;
#(
  parameter int IT_MAX_LEN = 4,
  parameter int LENW       = $clog2(IT_MAX_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  PCS,
  input  logic                  RegW,
  input  logic                  MemW,
  input  logic                  NoWrite,
  input  logic [3:0]            Cond,
  input  logic [3:0]            ALUFlags,
  input  logic [1:0]            FlagW,
  input  logic                  ITStart,
  input  logic [3:0]            ITCond,
  input  logic [LENW-1:0]       ITLen,
  input  logic [IT_MAX_LEN-1:0] ITPattern,
  output logic                  PCSrc,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  CondEx,
  output logic [3:0]            Flags,
  output logic                  ITActive
);

  localparam logic [LENW-1:0] MAX_LEN = LENW'(IT_MAX_LEN);

  it_state_e             state_q, state_d;
  logic [LENW-1:0]       cnt_q, cnt_d;
  logic [LENW-1:0]       idx_q, idx_d;
  logic [3:0]            it_cond_q, it_cond_d;
  logic [IT_MAX_LEN-1:0] it_pat_q, it_pat_d;
  logic [3:0]            flags_q, flags_d;

  logic [IT_MAX_LEN-1:0] slot_sel;
  logic                  slot_then;
  logic [3:0]            eff_cond;
  logic                  cond_ex;
  logic [LENW-1:0]       len_clamped;

  // Else slots invert the low bit of the base condition; AL/NV stay true either way.
  always_comb begin
    slot_sel  = IT_MAX_LEN'(1) << idx_q;
    slot_then = |(it_pat_q & slot_sel);
    if (state_q == IT_ACTIVE) begin
      eff_cond = slot_then ? it_cond_q : {it_cond_q[3:1], ~it_cond_q[0]};
    end else begin
      eff_cond = Cond;
    end
  end

  cond_eval u_cond_eval (
    .cond  (eff_cond),
    .flags (flags_q),
    .pass  (cond_ex)
  );

  assign CondEx   = cond_ex;
  assign PCSrc    = en & cond_ex & PCS;
  assign RegWrite = en & cond_ex & RegW & ~NoWrite;
  assign MemWrite = en & cond_ex & MemW;
  assign Flags    = flags_q;
  assign ITActive = (state_q == IT_ACTIVE);

  always_comb begin
    flags_d = flags_q;
    if (en && cond_ex && FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
    if (en && cond_ex && FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    it_cond_d   = it_cond_q;
    it_pat_d    = it_pat_q;
    len_clamped = ((ITLen == '0) || (ITLen > MAX_LEN)) ? MAX_LEN : ITLen;
    case (state_q)
      IT_IDLE: begin
        if (en && ITStart && cond_ex) begin
          state_d   = IT_ACTIVE;
          it_cond_d = ITCond;
          it_pat_d  = ITPattern | IT_MAX_LEN'(1);
          cnt_d     = len_clamped;
          idx_d     = '0;
        end
      end
      IT_ACTIVE: begin
        // ITStart is deliberately ignored here; a taken branch ends the block early.
        if (en) begin
          if ((cnt_q <= LENW'(1)) || PCSrc) begin
            state_d = IT_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q - LENW'(1);
            idx_d = idx_q + LENW'(1);
          end
        end
      end
      default: state_d = IT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IT_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      it_cond_q <= '0;
      it_pat_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      it_cond_q <= it_cond_d;
      it_pat_q  <= it_pat_d;
      flags_q   <= flags_d;
    end
  end

endmodule
